alu_op_sequencer: RTL and testbench

- Sequencing controller in front of the team's combinational 16-bit ALU (add, sub, mul, div, mod; 32-bit result, 2-bit error).
- Accepts one operation at a time from a requester over a valid/ready handshake.
- Drives registered operands and command into the ALU, then waits a fixed settle time.
- Captures result and error flags, and holds them on a valid/ready response channel until consumed.

---
 rtl/alu_op_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose:
//   Sequencing controller that sits in front of a combinational 16-bit ALU. It takes one
//   operation at a time from a requester, registers the operands and command into the ALU,
//   waits SETTLE_CYCLES clock edges, and then captures the result and error flags. The
//   captured response is held on a valid/ready channel until the consumer takes it.
//   Illegal commands (5..15) are never sent to the ALU. They produce an immediate response
//   with rsp_illegal set.
//
// Optional feature (macro ALU_SEQ_CHAIN_EN):
//   Defining this macro adds the req_chain input and a 16-bit chain accumulator. The
//   accumulator holds the low half of the most recent legal result. When a legal request
//   arrives with req_chain=1, the accumulator replaces req_a as operand A.
//
// Parameters:
//   SETTLE_CYCLES  clock edges between ALU input launch and result capture (1..15)
//   CNT_W          width of the completed-operation counter
//
// Ports:
//   clk, rst                        clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready             request handshake; ready only while idle
//   req_a, req_b, req_cmd           operands and command (0 add,1 sub,2 mul,3 div,4 mod)
//   req_chain                       (ALU_SEQ_CHAIN_EN only) use chain accumulator as A
//   alu_a, alu_b, alu_cmd           registered ALU inputs
//   alu_result, alu_error           ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_error           captured ALU result and error flags
//   rsp_illegal                     command was illegal and was not issued
//   busy                            operation in flight or response pending
//   op_count                        completed legal operations (wrapping)
// ---------------------------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [3:0]       req_cmd,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             req_chain,
`endif
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_cmd,
  input  logic [31:0]      alu_result,
  input  logic [1:0]       alu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [1:0]       rsp_error,
  output logic             rsp_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] CmdMax     = 4'd4;
  // The counter is loaded at the accept edge, so capture lands SETTLE_CYCLES edges later.
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q,       state_d;
  logic [3:0]       cnt_q,         cnt_d;
  logic [15:0]      alu_a_q,       alu_a_d;
  logic [15:0]      alu_b_q,       alu_b_d;
  logic [3:0]       alu_cmd_q,     alu_cmd_d;
  logic             rsp_valid_q,   rsp_valid_d;
  logic [31:0]      rsp_result_q,  rsp_result_d;
  logic [1:0]       rsp_error_q,   rsp_error_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [CNT_W-1:0] op_count_q,    op_count_d;

  logic             cmd_legal;
  logic [15:0]      next_a;

  assign cmd_legal = (req_cmd <= CmdMax);

`ifdef ALU_SEQ_CHAIN_EN
  logic [15:0] chain_acc_q, chain_acc_d;

  assign next_a = req_chain ? chain_acc_q : req_a;
`else
  assign next_a = req_a;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cmd_d     = alu_cmd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_error_d   = rsp_error_q;
    rsp_illegal_d = rsp_illegal_q;
    op_count_d    = op_count_q;
`ifdef ALU_SEQ_CHAIN_EN
    chain_acc_d   = chain_acc_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (cmd_legal) begin
            alu_a_d   = next_a;
            alu_b_d   = req_b;
            alu_cmd_d = req_cmd;
            cnt_d     = SettleLoad;
            state_d   = StWait;
          end else begin
            // Illegal command: leave the ALU inputs untouched and answer at once.
            rsp_result_d  = 32'd0;
            rsp_error_d   = 2'd0;
            rsp_illegal_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = StDone;
          end
        end
      end

      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d  = alu_result;
          rsp_error_d   = alu_error;
          rsp_illegal_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = StDone;
`ifdef ALU_SEQ_CHAIN_EN
          chain_acc_d   = alu_result[15:0];
`endif
        end
      end

      StDone: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
          if (!rsp_illegal_q) begin
            op_count_d = op_count_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      alu_a_q       <= 16'd0;
      alu_b_q       <= 16'd0;
      alu_cmd_q     <= 4'd0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_error_q   <= 2'd0;
      rsp_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cmd_q     <= alu_cmd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_error_q   <= rsp_error_d;
      rsp_illegal_q <= rsp_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

`ifdef ALU_SEQ_CHAIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_acc_q <= 16'd0;
    end else begin
      chain_acc_q <= chain_acc_d;
    end
  end
`endif

  assign req_ready   = (state_q == StIdle);
  assign busy        = (state_q == StWait) || (state_q == StDone);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cmd     = alu_cmd_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_illegal = rsp_illegal_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a behavioural ALU is attached to the ALU port, and a
// reference model tracks the expected ALU inputs, responses, and op count.
module tb_alu_op_sequencer;

  localparam int unsigned Settle = 2;
  localparam int unsigned CntW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [15:0]     req_a;
  logic [15:0]     req_b;
  logic [3:0]      req_cmd;
  logic            req_chain;
  logic [15:0]     alu_a;
  logic [15:0]     alu_b;
  logic [3:0]      alu_cmd;
  logic [31:0]     alu_result;
  logic [1:0]      alu_error;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_result;
  logic [1:0]      rsp_error;
  logic            rsp_illegal;
  logic            busy;
  logic [CntW-1:0] op_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_a, m_b, m_chain;
  logic [3:0]  m_cmd;
  int unsigned m_count;

  // Last observed response, kept for directed checks
  logic [31:0] last_res;
  logic [1:0]  last_err;
  logic [15:0] last_alu_a;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .SETTLE_CYCLES(Settle),
    .CNT_W        (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cmd    (req_cmd),
`ifdef ALU_SEQ_CHAIN_EN
    .req_chain  (req_chain),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cmd    (alu_cmd),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .rsp_illegal(rsp_illegal),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Behavioural ALU: returns {error[1:0], result[31:0]}.
  function automatic logic [33:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] cmd);
    int          sa, sb, r;
    logic [31:0] res;
    logic [1:0]  err;
    res = 32'd0;
    err = 2'd0;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = 0;
    case (cmd)
      4'd0: begin
        r      = sa + sb;
        res    = 32'(r) & 32'h0000_FFFF;
        err[0] = (r > 32767) || (r < -32768);
      end
      4'd1: begin
        r      = sa - sb;
        res    = 32'(r) & 32'h0000_FFFF;
        err[0] = (r > 32767) || (r < -32768);
      end
      4'd2: res = 32'(a) * 32'(b);
      4'd3: if (b == 16'd0) err[1] = 1'b1; else res = 32'(a) / 32'(b);
      4'd4: if (b == 16'd0) err[1] = 1'b1; else res = 32'(a) % 32'(b);
      default: ;
    endcase
    return {err, res};
  endfunction

  always_comb begin
    {alu_error, alu_result} = ref_alu(alu_a, alu_b, alu_cmd);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
    return 32'(m_count & ((32'd1 << CntW) - 1));
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_alu_cmd"}, 32'(alu_cmd), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    chk({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'd0);
    chk({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  task automatic model_reset();
    m_a     = 16'd0;
    m_b     = 16'd0;
    m_cmd   = 4'd0;
    m_chain = 16'd0;
    m_count = 0;
  endtask

  // Issue one request, check latency and response, hold the response for 'hold' cycles,
  // then perform the response handshake. Inputs are driven and outputs sampled on negedges.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] cmd,
                       input logic chain, input int hold);
    logic        legal;
    logic [33:0] exp;
    legal = (cmd <= 4'd4);
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_a     = a;
    req_b     = b;
    req_cmd   = cmd;
    req_chain = chain;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    if (legal) begin
`ifdef ALU_SEQ_CHAIN_EN
      m_a = chain ? m_chain : a;
`else
      m_a = a;
`endif
      m_b   = b;
      m_cmd = cmd;
      exp   = ref_alu(m_a, m_b, m_cmd);
      for (int k = 0; k < int'(Settle); k++) begin
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        // Noise that must be ignored while the op is in flight.
        req_valid = 1'b1;
        req_a     = ~a;
        req_cmd   = 4'd1;
        rsp_ready = 1'b1;
        @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      m_chain   = exp[15:0];
    end else begin
      exp = 34'd0;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_result", rsp_result, exp[31:0]);
    chk("rsp_error", 32'(rsp_error), 32'(exp[33:32]));
    chk("rsp_illegal", 32'(rsp_illegal), 32'(!legal));
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("alu_cmd", 32'(alu_cmd), 32'(m_cmd));
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_req_ready", 32'(req_ready), 32'd0);
    last_res   = rsp_result;
    last_err   = rsp_error;
    last_alu_a = alu_a;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_result", rsp_result, exp[31:0]);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (legal) m_count++;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("op_count", 32'(op_count), exp_count());
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  rc;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = 16'd0;
    req_b     = 16'd0;
    req_cmd   = 4'd0;
    req_chain = 1'b0;
    rsp_ready = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // rsp_ready with nothing pending is ignored
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_rdy_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_rdy_op_count", 32'(op_count), 32'd0);

    // Signed-overflow add
    issue(16'h7FFF, 16'd3, 4'd0, 1'b0, 0);
    chk("plan_add_res", last_res, 32'h0000_8002);
    chk("plan_add_ovf", 32'(last_err[0]), 32'd1);
    chk("plan_add_count", 32'(op_count), 32'd1);

    // Divide with response held back for 5 cycles
    issue(16'd1000, 16'd7, 4'd3, 1'b0, 5);
    chk("plan_div_res", last_res, 32'd142);

    // Illegal command: ALU inputs and count unchanged
    issue(16'h1234, 16'h5678, 4'd9, 1'b0, 1);
    chk("plan_ill_res", last_res, 32'd0);
    chk("plan_ill_alu_cmd", 32'(alu_cmd), 32'd3);
    chk("plan_ill_count", 32'(op_count), 32'd2);

    // Modulus by zero, then multiply
    issue(16'd5, 16'd0, 4'd4, 1'b0, 0);
    chk("plan_mod0_err", 32'(last_err), 32'd2);
    chk("plan_mod0_res", last_res, 32'd0);
    issue(16'd300, 16'd200, 4'd2, 1'b0, 2);
    chk("plan_mul_res", last_res, 32'd60000);

    // Reset while an op is in flight
    @(negedge clk);
    req_a     = 16'd9;
    req_b     = 16'd4;
    req_cmd   = 4'd1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < int'(Settle) + 3; k++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    end

`ifdef ALU_SEQ_CHAIN_EN
    // Chained operand A
    issue(16'd10, 16'd5, 4'd2, 1'b0, 0);
    chk("chain_op1_res", last_res, 32'd50);
    issue(16'hFFFF, 16'd8, 4'd0, 1'b1, 0);
    chk("chain_alu_a", 32'(last_alu_a), 32'd50);
    chk("chain_res", last_res, 32'd58);
`endif

    // Randomized operations, including illegal commands and zero divisors
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      rc = 4'($urandom_range(0, 6));
      issue(ra, rb, rc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Counter wrap: bring the count to all-ones, then complete one more legal op
    for (int i = 0; i < 16; i++) begin
      if (exp_count() != ((32'd1 << CntW) - 1)) begin
        issue(16'($urandom), 16'($urandom), 4'd0, 1'b0, 0);
      end
    end
    chk("wrap_pre", 32'(op_count), (32'd1 << CntW) - 1);
    issue(16'd1, 16'd2, 4'd0, 1'b0, 0);
    chk("wrap_zero", 32'(op_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
